// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register, feeding a
// downstream serial sequence detector one bit per enabled clock.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clock,
  input  logic             R,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             en,
  output logic             w,
  output logic             w_valid,
  output logic             last,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             w_q, w_d;
  logic             w_valid_q, w_valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic             load;
  logic [WIDTH-1:0] shreg_next;

  // in_ready_q always equals !hold_full_q, so accept never needs a live
  // combinational view of the holding register.
  assign accept = in_valid && in_ready_q;

  assign shreg_next = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shreg_q[WIDTH-1:1]};

  // NOTE: combinational blocks use blocking '=' with a default for every
  // output first, so no latch is inferred; flops below use '<=' only.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      SHIFT: begin
        if (en) begin
          if (cnt_q == LAST_CNT) begin
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              shreg_d = '0;
              cnt_d   = '0;
            end
          end else begin
            shreg_d = shreg_next;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shreg_d     = hold_q;
      cnt_d       = '0;
      state_d     = SHIFT;
      hold_full_d = 1'b0;
    end

    // Accept only happens into an empty hold, so it never races a load.
    if (accept) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    in_ready_d = !hold_full_d;
    busy_d     = hold_full_d || (state_d == SHIFT);
    w_valid_d  = (state_d == SHIFT);
    w_d        = w_valid_d && (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]);
    last_d     = w_valid_d && (cnt_d == LAST_CNT);
  end

  always_ff @(posedge Clock) begin
    if (!R) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
      in_ready_q  <= 1'b1;
      w_q         <= 1'b0;
      w_valid_q   <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
      in_ready_q  <= in_ready_d;
      w_q         <= w_d;
      w_valid_q   <= w_valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
    end
  end

  // NOTE: the hold data needs no reset; hold_full_q alone qualifies it.
  always_ff @(posedge Clock) begin
    hold_q <= hold_d;
  end

  assign in_ready = in_ready_q;
  assign w        = w_q;
  assign w_valid  = w_valid_q;
  assign last     = last_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first instance for most scenarios
// and an LSB-first instance for bit ordering.
module tb_bit_serializer;

  logic       Clock = 1'b0;
  logic       R;
  logic       in_valid, en;
  logic [7:0] in_data;
  logic       in_ready, w, w_valid, last, busy;
  logic       in_valid_l, en_l;
  logic [7:0] in_data_l;
  logic       in_ready_l, w_l, w_valid_l, last_l, busy_l;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .Clock(Clock), .R(R), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .en(en), .w(w), .w_valid(w_valid),
    .last(last), .busy(busy)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .Clock(Clock), .R(R), .in_valid(in_valid_l), .in_data(in_data_l),
    .in_ready(in_ready_l), .en(en_l), .w(w_l), .w_valid(w_valid_l),
    .last(last_l), .busy(busy_l)
  );

  // Observed vectors are {w, w_valid, last, in_ready, busy}.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    R = 1'b0; in_valid = 1'b1; in_data = 8'hAA; en = 1'b1;
    tick(); tick();
    obs = {w, w_valid, last, in_ready, busy};
    checks++;
    if (obs !== 5'b00010) begin
      errors++; $display("FAIL reset_state got %b want %b", obs, 5'b00010);
    end
    R = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {w, w_valid, last, in_ready, busy};
      checks++;
      if (obs !== 5'b00010) begin
        errors++; $display("FAIL reset_idle%0d got %b want %b", i, obs, 5'b00010);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] bits = 8'b1011_0110;
    logic [4:0] obs, exp;
    in_valid = 1'b1; in_data = 8'hB6;
    tick();
    in_valid = 1'b0; in_data = 8'h00;
    obs = {w, w_valid, last, in_ready, busy};
    checks++;
    if (obs !== 5'b00001) begin
      errors++; $display("FAIL b6_accept got %b want %b", obs, 5'b00001);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      obs = {w, w_valid, last, in_ready, busy};
      exp = {bits[7-i], 1'b1, (i == 7), 1'b1, 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL b6_bit%0d got %b want %b", i, obs, exp);
      end
    end
    tick();
    obs = {w, w_valid, last, in_ready, busy};
    checks++;
    if (obs !== 5'b00010) begin
      errors++; $display("FAIL b6_done got %b want %b", obs, 5'b00010);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] obs, exp;
    in_valid = 1'b1; in_data = 8'hFF;
    tick();
    in_data = 8'h00;
    obs = {w, w_valid, last, in_ready, busy};
    checks++;
    if (obs !== 5'b00001) begin
      errors++; $display("FAIL b2b_accept got %b want %b", obs, 5'b00001);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 1) in_valid = 1'b0;
      obs = {w, w_valid, last, in_ready, busy};
      exp = {(i < 8), 1'b1, (i == 7 || i == 15), (i == 0 || i >= 8), 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL b2b_bit%0d got %b want %b", i, obs, exp);
      end
    end
    tick();
    obs = {w, w_valid, last, in_ready, busy};
    checks++;
    if (obs !== 5'b00010) begin
      errors++; $display("FAIL b2b_done got %b want %b", obs, 5'b00010);
    end
  endtask

  task automatic test_stall();
    logic [7:0] bits_a = 8'b1010_0101;
    logic [7:0] bits_b = 8'b0000_1111;
    logic [4:0] obs, exp;
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {w, w_valid, last, in_ready, busy};
      exp = {bits_a[7-i], 1'b1, 1'b0, 1'b1, 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL stall_pre%0d got %b want %b", i, obs, exp);
      end
    end
    en = 1'b0; in_valid = 1'b1; in_data = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      tick();
      in_valid = 1'b0;
      obs = {w, w_valid, last, in_ready, busy};
      checks++;
      if (obs !== 5'b11001) begin
        errors++; $display("FAIL stall_frozen%0d got %b want %b", i, obs, 5'b11001);
      end
    end
    en = 1'b1;
    for (int i = 3; i < 8; i++) begin
      tick();
      obs = {w, w_valid, last, in_ready, busy};
      exp = {bits_a[7-i], 1'b1, (i == 7), 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL stall_post%0d got %b want %b", i, obs, exp);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      obs = {w, w_valid, last, in_ready, busy};
      exp = {bits_b[7-i], 1'b1, (i == 7), 1'b1, 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL stall_next%0d got %b want %b", i, obs, exp);
      end
    end
    tick();
    obs = {w, w_valid, last, in_ready, busy};
    checks++;
    if (obs !== 5'b00010) begin
      errors++; $display("FAIL stall_done got %b want %b", obs, 5'b00010);
    end
  endtask

  task automatic test_hold_full();
    logic [23:0] stream = {8'hC3, 8'h81, 8'h3C};
    logic [4:0]  obs, exp;
    in_valid = 1'b1; in_data = 8'hC3;
    tick();
    in_data = 8'h81;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (i == 1) in_data = 8'h3C;
      if (i == 9) in_valid = 1'b0;
      obs = {w, w_valid, last, in_ready, busy};
      exp = {stream[23-i], 1'b1, (i % 8 == 7), (i == 0 || i == 8 || i >= 16), 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL holdfull_bit%0d got %b want %b", i, obs, exp);
      end
    end
    tick();
    obs = {w, w_valid, last, in_ready, busy};
    checks++;
    if (obs !== 5'b00010) begin
      errors++; $display("FAIL holdfull_done got %b want %b", obs, 5'b00010);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs, exp;
    in_valid = 1'b1; in_data = 8'hF0;
    tick();
    in_data = 8'h55;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) in_valid = 1'b0;
      obs = {w, w_valid, last, in_ready, busy};
      exp = {1'b1, 1'b1, 1'b0, (i == 0), 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL rstmid_bit%0d got %b want %b", i, obs, exp);
      end
    end
    R = 1'b0;
    tick();
    R = 1'b1;
    obs = {w, w_valid, last, in_ready, busy};
    checks++;
    if (obs !== 5'b00010) begin
      errors++; $display("FAIL rstmid_after got %b want %b", obs, 5'b00010);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      obs = {w, w_valid, last, in_ready, busy};
      checks++;
      if (obs !== 5'b00010) begin
        errors++; $display("FAIL rstmid_quiet%0d got %b want %b", i, obs, 5'b00010);
      end
    end
  endtask

  task automatic test_lsb_first();
    logic [4:0] obs, exp;
    in_valid_l = 1'b1; in_data_l = 8'h01;
    tick();
    in_valid_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      obs = {w_l, w_valid_l, last_l, in_ready_l, busy_l};
      exp = {(i == 0), 1'b1, (i == 7), 1'b1, 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL lsb_bit%0d got %b want %b", i, obs, exp);
      end
    end
    tick();
    obs = {w_l, w_valid_l, last_l, in_ready_l, busy_l};
    checks++;
    if (obs !== 5'b00010) begin
      errors++; $display("FAIL lsb_done got %b want %b", obs, 5'b00010);
    end
  endtask

  initial begin
    R = 1'b0; in_valid = 1'b0; in_data = 8'h00; en = 1'b1;
    in_valid_l = 1'b0; in_data_l = 8'h00; en_l = 1'b1;
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_hold_full();
    test_reset_mid();
    test_lsb_first();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
